// File: rtl/alu_pkg.sv
// Constants shared by the ALU top level and the multi-cycle multiply unit:
// funct codes and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_reg.sv
// Hi/Lo result register pair: written together on a single enable,
// cleared asynchronously by the active-low reset.
module hilo_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: rtl/multu_hilo.sv
// Iterative shift-add unsigned multiplier feeding the Hi/Lo registers, plus
// the MFHI/MFLO read mux that the ALU output stage consumes.
module multu_hilo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter logic [5:0]  F_MULTU = alu_pkg::F_MULTU,
  parameter logic [5:0]  F_MFHI  = alu_pkg::F_MFHI,
  parameter logic [5:0]  F_MFLO  = alu_pkg::F_MFLO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] Output
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [5:0]       prev_sig;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   sum;
  logic             start;
  logic             last_iter;
  logic             hilo_we;

  // Only a rising edge onto MULTU starts work, so a held funct code runs once.
  assign start     = (Signal == F_MULTU) && (prev_sig != F_MULTU) && (state == ST_IDLE);
  assign last_iter = (count == CW'(WIDTH - 1));
  assign sum       = acc + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (last_iter) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    done    = (state == ST_COMMIT);
    hilo_we = (state == ST_COMMIT);
  end

  // The product accumulates in {acc, mplier}: each step adds the multiplicand
  // into the top half and shifts the consumed multiplier bit out the bottom.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sig <= '0;
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else begin
      prev_sig <= Signal;
      if (start) begin
        mcand  <= dataA;
        mplier <= dataB;
        acc    <= '0;
        count  <= '0;
      end else if (state == ST_RUN) begin
        acc    <= {1'b0, sum[WIDTH:1]};
        mplier <= {sum[0], mplier[WIDTH-1:1]};
        count  <= count + CW'(1);
      end
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .reset (reset),
    .we    (hilo_we),
    .hi_d  (acc[WIDTH-1:0]),
    .lo_d  (mplier),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    case (Signal)
      F_MFHI:  Output = hi;
      F_MFLO:  Output = lo;
      default: Output = '0;
    endcase
  end

endmodule
